// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constants for the iterative CORDIC engine.
// Real-valued constants are quantised by the users to their own fractional width.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ITER = 2'd2,
        POST = 2'd3
    } state_t;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    localparam real K_REAL  = 0.6072529350088813;
    localparam real PI_REAL = 3.141592653589793;

    // Positive constants only; round to nearest at the requested fractional width.
    function automatic longint quantise(input real v, input int frac);
        real scaled;
        scaled = v * real'(longint'(1) << frac);
        return longint'($rtoi(scaled + 0.5));
    endfunction

    function automatic longint k_const(input int frac);
        return quantise(K_REAL, frac);
    endfunction

    function automatic longint half_pi_const(input int frac);
        return quantise(PI_REAL / 2.0, frac);
    endfunction

    function automatic longint pi_const(input int frac);
        return quantise(PI_REAL, frac);
    endfunction

    function automatic real atan_real(input int i);
        case (i)
            0:       return 0.7853981633974483;
            1:       return 0.4636476090008061;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            4:       return 0.06241880999595735;
            5:       return 0.031239833430268277;
            6:       return 0.015623728620476831;
            7:       return 0.007812341060101111;
            8:       return 0.0039062301319669718;
            9:       return 0.0019531225164788188;
            10:      return 0.0009765621895593195;
            11:      return 0.0004882812111948983;
            12:      return 0.00024414062014936177;
            13:      return 0.00012207031189367021;
            14:      return 0.00006103515617420877;
            default: return 1.0 / real'(longint'(1) << i);
        endcase
    endfunction

    function automatic longint atan_const(input int i, input int frac);
        return quantise(atan_real(i), frac);
    endfunction

endpackage

// File: rtl/cordic_iter_par_if.sv
// Start/done handshake plus operand and result bus of the iterative CORDIC engine.
interface cordic_iter_par_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] angle_in;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;

    modport master (
        output start, mode, angle_in, x_in, y_in,
        input  busy, done, err, res_a, res_b
    );

    modport slave (
        input  start, mode, angle_in, x_in, y_in,
        output busy, done, err, res_a, res_b
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) table in Q3 with GUARD extra fraction bits.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = 14,
    parameter int GUARD = 2
) (
    input  logic [$clog2(ITERS)-1:0]     idx,
    output logic signed [WIDTH+GUARD-1:0] value
);
    localparam int AW   = WIDTH + GUARD;
    localparam int FRAC = WIDTH - 3 + GUARD;

    logic signed [AW-1:0] atan_tbl [ITERS];

    for (genvar j = 0; j < ITERS; j++) begin : g_tbl
        assign atan_tbl[j] = AW'(atan_const(j, FRAC));
    end

    assign value = (32'(idx) < ITERS) ? atan_tbl[idx] : '0;
endmodule

// File: rtl/cordic_iter_par.sv
// Iterative CORDIC, one micro-rotation per clock, rotation (sin/cos) and vectoring (atan2/mag).
// Define CORDIC_QUAD_EXT_EN for full-circle quadrant folding; GUARD must be at least 1.
module cordic_iter_par
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = 14,
    parameter int GUARD = 2
) (
    input logic              clk,
    input logic              rst_n,
    cordic_iter_par_if.slave bus
);
    localparam int IW    = WIDTH + GUARD + 1;
    localparam int AW    = WIDTH + GUARD;
    localparam int IDXW  = $clog2(ITERS);
    localparam int ZFRAC = WIDTH - 3 + GUARD;
    localparam int XFRAC = WIDTH - 2 + GUARD;

    localparam logic signed [IW-1:0] K_INIT    = IW'(k_const(XFRAC));
    localparam logic signed [IW-1:0] HALF_PI_Z = IW'(half_pi_const(ZFRAC));
`ifdef CORDIC_QUAD_EXT_EN
    localparam logic signed [IW-1:0] PI_Z      = IW'(pi_const(ZFRAC));
`endif
    localparam logic signed [IW:0] HALF_LSB = (IW+1)'(1) << (GUARD - 1);
    localparam logic signed [IW:0] OUT_MAX  = {{(GUARD+3){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [IW:0] OUT_MIN  = {{(GUARD+3){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t state, next_state;

    logic                   mode_q;
    logic [WIDTH-1:0]       angle_q, xin_q, yin_q;
    logic signed [IW-1:0]   x_q, y_q, z_q;
    logic [IDXW-1:0]        iter_cnt;
    logic                   neg_q, err_pend_q, zero_q;
    logic                   done_q, err_q;
    logic [WIDTH-1:0]       res_a_q, res_b_q;

    logic signed [IW-1:0]   angle_z, xv, yv;
    logic signed [IW-1:0]   pre_x, pre_y, pre_z;
    logic                   pre_neg, pre_err, pre_zero;
    logic signed [IW-1:0]   x_sh, y_sh, atan_ext;
    logic signed [AW-1:0]   atan_val;
    logic                   dir_pos;

    function automatic logic signed [IW-1:0] ext(input logic [WIDTH-1:0] v);
        return {{(IW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Round half-up on the guard bits, then clamp to the signed output range.
    function automatic logic [WIDTH-1:0] to_out(input logic signed [IW-1:0] v);
        logic signed [IW:0] r;
        r = {v[IW-1], v} + HALF_LSB;
        r = r >>> GUARD;
        if (r > OUT_MAX)      return {1'b0, {(WIDTH-1){1'b1}}};
        else if (r < OUT_MIN) return {1'b1, {(WIDTH-1){1'b0}}};
        else                  return r[WIDTH-1:0];
    endfunction

    cordic_atan_rom #(.WIDTH(WIDTH), .ITERS(ITERS), .GUARD(GUARD)) u_rom (
        .idx   (iter_cnt),
        .value (atan_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = PRE;
            PRE:     next_state = ITER;
            ITER:    if (iter_cnt == IDXW'(ITERS - 1)) next_state = POST;
            POST:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Vectoring operands are carried in Q3 so the An gain cannot overflow the datapath.
    assign angle_z = ext(angle_q) <<< GUARD;
    assign xv      = ext(xin_q) <<< (GUARD - 1);
    assign yv      = ext(yin_q) <<< (GUARD - 1);

    always_comb begin
        pre_x    = '0;
        pre_y    = '0;
        pre_z    = '0;
        pre_neg  = 1'b0;
        pre_err  = 1'b0;
        pre_zero = 1'b0;
        if (mode_q == MODE_ROT) begin
            pre_x = K_INIT;
            pre_z = angle_z;
`ifdef CORDIC_QUAD_EXT_EN
            if (angle_z > PI_Z || angle_z < -PI_Z) begin
                pre_err = 1'b1;
            end else if (angle_z > HALF_PI_Z) begin
                pre_z   = angle_z - PI_Z;
                pre_neg = 1'b1;
            end else if (angle_z < -HALF_PI_Z) begin
                pre_z   = angle_z + PI_Z;
                pre_neg = 1'b1;
            end
`else
            if (angle_z > HALF_PI_Z || angle_z < -HALF_PI_Z) pre_err = 1'b1;
`endif
        end else begin
            pre_x    = xv;
            pre_y    = yv;
            pre_zero = (xin_q == '0) && (yin_q == '0);
`ifdef CORDIC_QUAD_EXT_EN
            if (xv[IW-1]) begin
                pre_x = -xv;
                pre_y = -yv;
                pre_z = yv[IW-1] ? -PI_Z : PI_Z;
            end
`else
            if (xv[IW-1]) pre_err = 1'b1;
`endif
        end
    end

    assign x_sh     = x_q >>> iter_cnt;
    assign y_sh     = y_q >>> iter_cnt;
    assign atan_ext = {atan_val[AW-1], atan_val};
    assign dir_pos  = (mode_q == MODE_ROT) ? ~z_q[IW-1] : y_q[IW-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_ROT;
            angle_q    <= '0;
            xin_q      <= '0;
            yin_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            iter_cnt   <= '0;
            neg_q      <= 1'b0;
            err_pend_q <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            res_a_q    <= '0;
            res_b_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        angle_q <= bus.angle_in;
                        xin_q   <= bus.x_in;
                        yin_q   <= bus.y_in;
                    end
                end
                PRE: begin
                    x_q        <= pre_x;
                    y_q        <= pre_y;
                    z_q        <= pre_z;
                    neg_q      <= pre_neg;
                    err_pend_q <= pre_err;
                    zero_q     <= pre_zero;
                    iter_cnt   <= '0;
                end
                ITER: begin
                    if (dir_pos) begin
                        x_q <= x_q - y_sh;
                        y_q <= y_q + x_sh;
                        z_q <= z_q - atan_ext;
                    end else begin
                        x_q <= x_q + y_sh;
                        y_q <= y_q - x_sh;
                        z_q <= z_q + atan_ext;
                    end
                    iter_cnt <= iter_cnt + 1'b1;
                end
                POST: begin
                    done_q <= 1'b1;
                    err_q  <= err_pend_q;
                    if (err_pend_q || zero_q) begin
                        res_a_q <= '0;
                        res_b_q <= '0;
                    end else if (mode_q == MODE_VEC) begin
                        res_a_q <= to_out(z_q);
                        res_b_q <= to_out(x_q);
                    end else if (neg_q) begin
                        res_a_q <= to_out(-y_q);
                        res_b_q <= to_out(-x_q);
                    end else begin
                        res_a_q <= to_out(y_q);
                        res_b_q <= to_out(x_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.res_a = res_a_q;
    assign bus.res_b = res_b_q;
endmodule

// File: tb/tb_cordic_iter_par.sv
// Directed bench for cordic_iter_par at WIDTH=16, ITERS=14, GUARD=2; CORDIC results allow +-4 LSB.
// Expectations for 150 degrees and negative-x vectoring depend on CORDIC_QUAD_EXT_EN.
module tb_cordic_iter_par;
    localparam int TOL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   done_seen;

    cordic_iter_par_if #(.WIDTH(16)) bus ();

    cordic_iter_par #(.WIDTH(16), .ITERS(14), .GUARD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic signed [31:0] s16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
        checks++;
        assert ((observed >= expected - TOL) && (observed <= expected + TOL))
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d +-%0d", tag, observed, expected, TOL);
        end
    endtask

    // Start one operation, optionally pulse start again n cycles later, and return done latency.
    task automatic apply_stimulus(input logic m, input int ang, input int xi, input int yi,
                                  input int pulse_at, output int latency);
        bus.mode     = m;
        bus.angle_in = 16'(ang);
        bus.x_in     = 16'(xi);
        bus.y_in     = 16'(yi);
        bus.start    = 1'b1;
        wait_cycle();
        bus.start = 1'b0;
        check_output("busy_after_accept", 32'(bus.busy), 1);
        latency = -1;
        for (int n = 1; n <= 40; n++) begin
            bus.start = (n == pulse_at);
            wait_cycle();
            if (bus.done === 1'b1) begin
                latency = n;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start    = 1'b1;
        bus.mode     = 1'b0;
        bus.angle_in = '0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        rst_n        = 1'b0;
        repeat (3) wait_cycle();
        check_output("reset_busy", 32'(bus.busy), 0);
        check_output("reset_done", 32'(bus.done), 0);
        check_output("reset_err", 32'(bus.err), 0);
        check_output("reset_res_a", s16(bus.res_a), 0);
        check_output("reset_res_b", s16(bus.res_b), 0);

        rst_n = 1'b1;
        apply_stimulus(1'b0, 0, 0, 0, 0, lat);
        check_output("rot0_latency", lat, 16);
        check_near("rot0_sin", s16(bus.res_a), 0);
        check_near("rot0_cos", s16(bus.res_b), 16384);
        check_output("rot0_err", 32'(bus.err), 0);
        wait_cycle();
        check_output("done_one_cycle", 32'(bus.done), 0);
        check_near("result_hold", s16(bus.res_b), 16384);

        apply_stimulus(1'b0, 4289, 0, 0, 6, lat);
        check_output("rot30_latency", lat, 16);
        check_near("rot30_sin", s16(bus.res_a), 8192);
        check_near("rot30_cos", s16(bus.res_b), 14189);
        check_output("rot30_err", 32'(bus.err), 0);
        wait_cycle();
        check_output("start_not_queued", 32'(bus.busy), 0);

        apply_stimulus(1'b0, -4289, 0, 0, 0, lat);
        check_near("rotm30_sin", s16(bus.res_a), -8192);
        check_near("rotm30_cos", s16(bus.res_b), 14189);

        apply_stimulus(1'b0, 12868, 0, 0, 0, lat);
        check_near("rot90_sin", s16(bus.res_a), 16384);
        check_near("rot90_cos", s16(bus.res_b), 0);
        check_output("rot90_err", 32'(bus.err), 0);

        apply_stimulus(1'b0, 21447, 0, 0, 0, lat);
`ifdef CORDIC_QUAD_EXT_EN
        check_output("rot150_err", 32'(bus.err), 0);
        check_near("rot150_sin", s16(bus.res_a), 8192);
        check_near("rot150_cos", s16(bus.res_b), -14189);
`else
        check_output("rot150_err", 32'(bus.err), 1);
        check_output("rot150_sin", s16(bus.res_a), 0);
        check_output("rot150_cos", s16(bus.res_b), 0);
`endif

        apply_stimulus(1'b1, 0, 0, 0, 0, lat);
        check_output("vec_zero_err", 32'(bus.err), 0);
        check_output("vec_zero_a", s16(bus.res_a), 0);
        check_output("vec_zero_b", s16(bus.res_b), 0);

        apply_stimulus(1'b1, 0, -8192, 0, 0, lat);
`ifdef CORDIC_QUAD_EXT_EN
        check_output("vec_negx_err", 32'(bus.err), 0);
        check_near("vec_negx_atan", s16(bus.res_a), 25736);
        check_near("vec_negx_mag", s16(bus.res_b), 6745);
`else
        check_output("vec_negx_err", 32'(bus.err), 1);
        check_output("vec_negx_atan", s16(bus.res_a), 0);
        check_output("vec_negx_mag", s16(bus.res_b), 0);
`endif

        apply_stimulus(1'b1, 0, 8192, 8192, 0, lat);
        check_output("vec45_latency", lat, 16);
        check_output("vec45_err", 32'(bus.err), 0);
        check_near("vec45_atan", s16(bus.res_a), 6434);
        check_near("vec45_mag", s16(bus.res_b), 9539);

        bus.mode     = 1'b0;
        bus.angle_in = 16'd4289;
        bus.start    = 1'b1;
        wait_cycle();
        bus.start = 1'b0;
        repeat (5) wait_cycle();
        check_output("abort_busy_before", 32'(bus.busy), 1);
        rst_n = 1'b0;
        wait_cycle();
        check_output("abort_busy", 32'(bus.busy), 0);
        check_output("abort_done", 32'(bus.done), 0);
        check_output("abort_err", 32'(bus.err), 0);
        check_output("abort_res_a", s16(bus.res_a), 0);
        check_output("abort_res_b", s16(bus.res_b), 0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 24; n++) begin
            wait_cycle();
            if (bus.done === 1'b1) done_seen++;
        end
        check_output("abort_no_done", done_seen, 0);

        apply_stimulus(1'b0, 4289, 0, 0, 0, lat);
        check_output("after_abort_latency", lat, 16);
        check_near("after_abort_sin", s16(bus.res_a), 8192);
        check_near("after_abort_cos", s16(bus.res_b), 14189);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
